// File: rtl/fpu_issue_queue.sv
// In-order issue FIFO between the integer core's offload port and the FPU wrapper.
// Screens non-FP opcodes, answers every handshake with a one-cycle response, and holds the head while the FPU stalls.
module fpu_issue_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FLEN       = 32
) (
  input  logic                    ck,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instruction,
  input  logic [X_ID_WIDTH-1:0]   in_id,
  input  logic [XLEN-1:0]         in_data_fromXreg,
  input  logic [FLEN-1:0]         in_data_fromMem,
  output logic                    resp_valid,
  output logic                    resp_accept,
  output logic [X_ID_WIDTH-1:0]   resp_id,
  output logic                    fpu_enable,
  output logic [31:0]             fpu_instruction,
  output logic [X_ID_WIDTH-1:0]   fpu_id,
  output logic [XLEN-1:0]         fpu_data_fromXreg,
  output logic [FLEN-1:0]         fpu_data_fromMem,
  input  logic                    fpu_stall,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_accept_q, resp_accept_d;
  logic [X_ID_WIDTH-1:0] resp_id_q, resp_id_d;

  logic [31:0]           instr_mem [DEPTH];
  logic [X_ID_WIDTH-1:0] id_mem    [DEPTH];
  logic [XLEN-1:0]       xreg_mem  [DEPTH];
  logic [FLEN-1:0]       fmem_mem  [DEPTH];

  logic is_fp_c, hs_c, push_c, pop_c;

  // FP opcode screen on instruction bits [6:0]
  always_comb begin
    is_fp_c = 1'b0;
    case (in_instruction[6:0])
      7'b0000111, 7'b0100111,
      7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111,
      7'b1010011: is_fp_c = 1'b1;
      default:    is_fp_c = 1'b0;
    endcase
  end

  assign in_ready   = (count_q < CNT_W'(DEPTH));
  assign fpu_enable = (count_q != '0);
  assign hs_c       = in_valid && in_ready;
  assign push_c     = hs_c && is_fp_c && !flush;
  assign pop_c      = fpu_enable && !fpu_stall;

  // Next-state: flush wins over push and pop; a pop in the flush cycle was still issued
  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    resp_valid_d  = hs_c;
    resp_accept_d = push_c;
    resp_id_d     = hs_c ? in_id : resp_id_q;
    if (flush) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push_c) tail_d = tail_q + PTR_W'(1);
      if (pop_c)  head_d = head_q + PTR_W'(1);
      if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
      else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      resp_valid_q  <= 1'b0;
      resp_accept_q <= 1'b0;
      resp_id_q     <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      resp_valid_q  <= resp_valid_d;
      resp_accept_q <= resp_accept_d;
      resp_id_q     <= resp_id_d;
    end
  end

  // Entry storage carries no reset; contents only matter while counted
  always_ff @(posedge ck) begin
    if (push_c) begin
      instr_mem[tail_q] <= in_instruction;
      id_mem[tail_q]    <= in_id;
      xreg_mem[tail_q]  <= in_data_fromXreg;
      fmem_mem[tail_q]  <= in_data_fromMem;
    end
  end

  assign fpu_instruction   = instr_mem[head_q];
  assign fpu_id            = id_mem[head_q];
  assign fpu_data_fromXreg = xreg_mem[head_q];
  assign fpu_data_fromMem  = fmem_mem[head_q];

  assign count       = count_q;
  assign resp_valid  = resp_valid_q;
  assign resp_accept = resp_accept_q;
  assign resp_id     = resp_id_q;

endmodule
